mips_muldiv_unit: RTL

Multi-cycle multiply/divide unit with architectural HI/LO registers, executing the R-type MULT, MULTU, DIV, DIVU, MTHI and MTLO functs. It sits in the execute stage beside the ALU. It consumes the rs/rt operand values and the decoded funct. HI/LO feed the register-write mux that serves MFHI/MFLO. The control path stalls issue while `busy` is high.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mips_muldiv_step.sv | 51 +++++
 rtl/mips_muldiv_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS execute stage,
//               including the multiply/divide unit (funct codes, FSM state
//               encoding and iteration count).
// Revision    : 1.0 - initial multiply/divide additions
// ============================================================================
package mips_pkg;

    localparam int DATA_MEM_WIDTH = 32;
    localparam int MULDIV_ITERS   = 32;

    typedef logic [2*DATA_MEM_WIDTH-1:0] dword_t;

    // R-type funct field values handled around the HI/LO registers
    typedef enum logic [5:0] {
        F_MFHI  = 6'h10,
        F_MTHI  = 6'h11,
        F_MFLO  = 6'h12,
        F_MTLO  = 6'h13,
        F_MULT  = 6'h18,
        F_MULTU = 6'h19,
        F_DIV   = 6'h1A,
        F_DIVU  = 6'h1B
    } funct_t;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_RUN    = 2'd1,
        MD_FINISH = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv(input funct_t f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv_step
// Description : One radix-2 iteration of the multiply/divide unit (purely
//               combinational).
//               Multiply : acc = {partial_product, multiplier}; add the
//                          multiplicand into the upper half when acc[0] is set,
//                          then shift the whole register right by one.
//               Divide   : acc = {remainder, dividend/quotient}; shift left by
//                          one, trial-subtract the divisor from the upper half
//                          and, when it does not borrow, keep the difference
//                          and set the new quotient bit.
// Ports       : i_is_div  - 1 selects the divide step, 0 the multiply step
//               i_acc     - 2*DATA_W working register in
//               i_operand - multiplicand (multiply) or divisor (divide)
//               o_acc     - working register after this step
// Revision    : 1.0 - initial release
// ============================================================================
module mips_muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic                i_is_div,
    input  logic [2*DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0]   i_operand,
    output logic [2*DATA_W-1:0] o_acc
);

    logic [DATA_W:0] w_mul_sum;
    logic [DATA_W:0] w_trial;

    // The carry out of the add becomes the top bit after the right shift.
    assign w_mul_sum = {1'b0, i_acc[2*DATA_W-1:DATA_W]}
                     + (i_acc[0] ? {1'b0, i_operand} : {(DATA_W+1){1'b0}});

    // The bit shifted out of the top is kept as the 33rd bit of the trial
    // remainder so a shifted remainder >= 2^DATA_W still compares correctly.
    assign w_trial = i_acc[2*DATA_W-1:DATA_W-1] - {1'b0, i_operand};

    always_comb begin
        o_acc = {w_mul_sum, i_acc[DATA_W-1:1]};
        if (i_is_div) begin
            if (!w_trial[DATA_W]) begin
                o_acc = {w_trial[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
            end else begin
                o_acc = {i_acc[2*DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO
//               registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO). Operands are
//               converted to magnitudes when issued, iterated one bit per
//               cycle in mips_muldiv_step, and sign-corrected when HI/LO are
//               written.
// Config      : `define MIPS_MULDIV_FAST_MUL_EN for a single-cycle multiplier
//               (MULT/MULTU go IDLE -> FINISH directly). Divide is unaffected.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, funct      - request valid (sampled in IDLE) and op
//               rs_val, rt_val    - operands
//               busy              - multiply/divide in flight
//               done              - one-cycle pulse, HI/LO hold new result
//               hi, lo            - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
import mips_pkg::*;

module mips_muldiv_unit #(
    parameter int DATA_W = DATA_MEM_WIDTH,
    parameter int ITERS  = MULDIV_ITERS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  funct_t            funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    muldiv_state_t       r_state;
    muldiv_state_t       w_next_state;

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] w_step_acc;
    logic [DATA_W-1:0]   r_operand;
    logic [DATA_W-1:0]   r_rs_raw;
    logic                r_is_div;
    logic                r_neg_lo;     // product / quotient negation
    logic                r_neg_hi;     // remainder takes the dividend's sign
    logic                r_div_zero;
    logic [CNT_W-1:0]    r_count;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_idle;
    logic                w_write_result;
    logic                w_start_md;
    logic                w_start_mt;
    logic                w_is_div_op;
    logic                w_signed_op;
    logic                w_fast_mul;
    logic                w_last_step;
    logic [DATA_W-1:0]   w_rs_abs;
    logic [DATA_W-1:0]   w_rt_abs;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_new_hi;
    logic [DATA_W-1:0]   w_new_lo;

    // ------------------------------------------------------------------
    // Request decode and operand magnitudes
    // ------------------------------------------------------------------
    assign w_is_div_op = (funct == F_DIV) || (funct == F_DIVU);
    assign w_signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign w_start_md  = start && w_idle && is_muldiv(funct);
    assign w_start_mt  = start && w_idle && ((funct == F_MTHI) || (funct == F_MTLO));
    assign w_rs_abs    = (w_signed_op && rs_val[DATA_W-1]) ? -rs_val : rs_val;
    assign w_rt_abs    = (w_signed_op && rt_val[DATA_W-1]) ? -rt_val : rt_val;
    assign w_last_step = (r_count == CNT_W'(ITERS-1));

`ifdef MIPS_MULDIV_FAST_MUL_EN
    assign w_fast_mul = !w_is_div_op;
`else
    assign w_fast_mul = 1'b0;
`endif

    mips_muldiv_step #(
        .DATA_W    (DATA_W)
    ) u_step (
        .i_is_div  (r_is_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MD_IDLE:   if (w_start_md) w_next_state = w_fast_mul ? MD_FINISH : MD_RUN;
            MD_RUN:    if (w_last_step) w_next_state = MD_FINISH;
            MD_FINISH: w_next_state = MD_IDLE;
            default:   w_next_state = MD_IDLE;
        endcase
    end

    always_comb begin
        w_idle         = (r_state == MD_IDLE);
        w_write_result = (r_state == MD_FINISH);
        busy           = (r_state != MD_IDLE);
    end

    // ------------------------------------------------------------------
    // Sign correction applied on the way into HI/LO
    // ------------------------------------------------------------------
    assign w_prod = r_neg_lo ? -r_acc : r_acc;
    assign w_quot = r_neg_lo ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_hi ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_comb begin
        w_new_hi = w_prod[2*DATA_W-1:DATA_W];
        w_new_lo = w_prod[DATA_W-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_new_hi = r_rs_raw;
                w_new_lo = {DATA_W{1'b1}};
            end else begin
                w_new_hi = w_rem;
                w_new_lo = w_quot;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_operand  <= '0;
            r_rs_raw   <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= w_write_result || w_start_mt;

            if (w_start_md) begin
                r_is_div   <= w_is_div_op;
                r_rs_raw   <= rs_val;
                r_div_zero <= w_is_div_op && (rt_val == '0);
                r_neg_lo   <= w_signed_op && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
                r_neg_hi   <= w_signed_op && (w_is_div_op ? rs_val[DATA_W-1]
                                                          : (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]));
                r_count    <= '0;
                if (w_is_div_op) begin
                    r_operand <= w_rt_abs;
                    r_acc     <= {{DATA_W{1'b0}}, w_rs_abs};
                end else begin
                    r_operand <= w_rs_abs;
`ifdef MIPS_MULDIV_FAST_MUL_EN
                    r_acc     <= {{DATA_W{1'b0}}, w_rs_abs} * {{DATA_W{1'b0}}, w_rt_abs};
`else
                    r_acc     <= {{DATA_W{1'b0}}, w_rt_abs};
`endif
                end
            end else if (r_state == MD_RUN) begin
                r_acc   <= w_step_acc;
                r_count <= r_count + 1'b1;
            end

            if (w_write_result) begin
                r_hi <= w_new_hi;
                r_lo <= w_new_lo;
            end else if (w_start_mt) begin
                if (funct == F_MTHI) begin
                    r_hi <= rs_val;
                end else begin
                    r_lo <= rs_val;
                end
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
